// File: rtl/dmem_pkg.sv
// Shared encodings and derived sizes for the byte-addressed data memory.
package dmem_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam int DMEM_DEPTH    = 1024;
  localparam int MEM_ADDR_BITS = $clog2(DMEM_DEPTH);

endpackage

// File: rtl/data_mem.sv
// Little-endian byte-cell data memory: synchronous writes, combinational
// zero-extended reads, async clear of every cell on reset.
module data_mem
  import dmem_pkg::*;
#(
  parameter int WIDTH_ADDR_LENGTH = 32,
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int MEM_DEPTH         = DMEM_DEPTH,
  parameter int WIDTH_MEM_LENGTH  = 8,
  parameter int LENGHT_MUX        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_ADDR_LENGTH-1:0] Addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] DataW,
  input  logic                         MemRW,
  input  logic [LENGHT_MUX-1:0]        LenSel,
  output logic [WIDTH_DATA_LENGTH-1:0] DataR
);

  localparam int ADDR_BITS = $clog2(MEM_DEPTH);
  localparam int NUM_LANES = WIDTH_DATA_LENGTH / WIDTH_MEM_LENGTH;

  logic [MEM_DEPTH-1:0][WIDTH_MEM_LENGTH-1:0] mem_q, mem_d;
  logic [ADDR_BITS-1:0]                       base;
  logic [NUM_LANES-1:0]                       lane_en;
  logic [NUM_LANES-1:0][ADDR_BITS-1:0]        lane_idx;
  logic [NUM_LANES-1:0][WIDTH_MEM_LENGTH-1:0] lane_wdata, lane_rdata;

  // Address bits above the memory size are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[WIDTH_ADDR_LENGTH-1:ADDR_BITS];

  assign base = Addr[ADDR_BITS-1:0];

  // Lanes touched by the access; reserved size touches none.
  always_comb begin
    lane_en = '0;
    case (LenSel)
      LEN_BYTE: lane_en = NUM_LANES'(1);
      LEN_HALF: lane_en = NUM_LANES'(3);
      LEN_WORD: lane_en = '1;
      default:  lane_en = '0;
    endcase
  end

  // Lane k maps to cell base+k; the natural ADDR_BITS overflow gives the wrap.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_idx[k]   = base + ADDR_BITS'(k);
    assign lane_wdata[k] = DataW[k*WIDTH_MEM_LENGTH +: WIDTH_MEM_LENGTH];
    assign lane_rdata[k] = lane_en[k] ? mem_q[lane_idx[k]] : '0;
  end

  assign DataR = lane_rdata;

  always_comb begin
    mem_d = mem_q;
    if (MemRW) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lane_en[k]) mem_d[lane_idx[k]] = lane_wdata[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] Addr = '0;
  logic [31:0] DataW = '0;
  logic        MemRW = 1'b0;
  logic [1:0]  LenSel = 2'b10;
  logic [31:0] DataR;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Addr   (Addr),
    .DataW  (DataW),
    .MemRW  (MemRW),
    .LenSel (LenSel),
    .DataR  (DataR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Combinational read, sampled 1 time unit after driving, away from edges.
  task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] len,
                    input logic [31:0] exp);
    Addr = a; LenSel = len; MemRW = 1'b0;
    #1 chk(tag, DataR, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    @(negedge clk);
    Addr = a; LenSel = len; DataW = d; MemRW = 1'b1;
    @(negedge clk);
    MemRW = 1'b0;
  endtask

  initial begin
    // 1. reset then read
    #2 rst_n = 1'b0;
    #1 rd("rst_during", 32'h0, 2'b10, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("rst_w000", 32'h000, 2'b10, 32'h0);
    rd("rst_w100", 32'h100, 2'b10, 32'h0);
    rd("rst_w3fc", 32'h3FC, 2'b10, 32'h0);
    rd("rst_b3ff", 32'h3FF, 2'b00, 32'h0);

    // 2. mixed-size writes then word reads
    wr(32'h0, 2'b00, 32'h1234_5678);
    wr(32'h2, 2'b01, 32'h1234_5678);
    wr(32'h4, 2'b10, 32'h1234_5678);
    rd("w_at0", 32'h0, 2'b10, 32'h5678_0078);
    rd("w_at2", 32'h2, 2'b10, 32'h5678_5678);
    rd("w_at4", 32'h4, 2'b10, 32'h1234_5678);

    // read during write: old data before the edge, new data after
    @(negedge clk);
    Addr = 32'h8; LenSel = 2'b10; DataW = 32'hCAFE_F00D; MemRW = 1'b1;
    #1 chk("rdw_before", DataR, 32'h0);
    @(posedge clk);
    #1 chk("rdw_after", DataR, 32'hCAFE_F00D);
    MemRW = 1'b0;

    // 3. sub-word reads
    rd("b_at5", 32'h5, 2'b00, 32'h0000_0056);
    rd("h_at6", 32'h6, 2'b01, 32'h0000_1234);
    rd("h_at1", 32'h1, 2'b01, 32'h0000_7800);

    // 4. write disable and reserved size
    @(negedge clk);
    Addr = 32'h4; LenSel = 2'b10; DataW = 32'hDEAD_BEEF; MemRW = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("nowr_rw0", DataR, 32'h1234_5678);
    LenSel = 2'b11; MemRW = 1'b1;
    #1 chk("rsv_read0", DataR, 32'h0);
    repeat (2) @(negedge clk);
    MemRW = 1'b0;
    rd("rsv_nowrite", 32'h4, 2'b10, 32'h1234_5678);

    // 5. wrap-around and ignored upper address bits
    wr(32'h3FE, 2'b10, 32'hAABB_CCDD);
    rd("wrap_3fe", 32'h3FE, 2'b00, 32'h0000_00DD);
    rd("wrap_3ff", 32'h3FF, 2'b00, 32'h0000_00CC);
    rd("wrap_000", 32'h000, 2'b00, 32'h0000_00BB);
    rd("wrap_001", 32'h001, 2'b00, 32'h0000_00AA);
    rd("wrap_002", 32'h002, 2'b00, 32'h0000_0078);
    rd("hi_addr",  32'h0000_13FE, 2'b10, 32'hAABB_CCDD);
    rd("hi_half",  32'hFFFF_FFFF, 2'b01, 32'h0000_BBCC);

    // 6. async reset between edges with a write held
    @(negedge clk);
    Addr = 32'h4; LenSel = 2'b10; DataW = 32'h5555_AAAA; MemRW = 1'b0;
    #1 chk("pre_arst", DataR, 32'h1234_5678);
    #1 MemRW = 1'b1; rst_n = 1'b0;
    #1 chk("arst_now", DataR, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("arst_hold", DataR, 32'h0);
    rst_n = 1'b1; MemRW = 1'b0;
    rd("post_4",   32'h4,   2'b10, 32'h0);
    rd("post_3fe", 32'h3FE, 2'b10, 32'h0);
    rd("post_8",   32'h8,   2'b10, 32'h0);
    rd("post_0",   32'h0,   2'b01, 32'h0);

    // memory still writable after reset
    wr(32'h10, 2'b01, 32'h0000_BEEF);
    rd("post_wr", 32'h10, 2'b10, 32'h0000_BEEF);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Byte-addressed data memory for the RISC-V core's MEM stage.
- Stores 1 KiB as 8-bit cells.
- Supports byte, halfword and word accesses, little-endian.
- Writes are synchronous on the clock edge. Reads are combinational and zero-extended; sign extension belongs to the core's load-extend logic.

Parameters:
- WIDTH_ADDR_LENGTH, 32, address bus width.
- WIDTH_DATA_LENGTH, 32, read/write data width.
- MEM_DEPTH, 1024, number of byte cells (power of two).
- WIDTH_MEM_LENGTH, 8, cell width.
- LENGHT_MUX, 2, LenSel width.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Addr  input  WIDTH_ADDR_LENGTH  byte address; only the low log2(MEM_DEPTH) bits (Addr[9:0]) are used, upper bits ignored.
- DataW  input  WIDTH_DATA_LENGTH  write data; the access size selects the low 8/16/32 bits.
- MemRW  input  1  1 = write, 0 = read only.
- LenSel  input  LENGHT_MUX  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- DataR  output  WIDTH_DATA_LENGTH  read data.

Interface note: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: while rst_n = 0, all MEM_DEPTH cells are cleared to 0x00 immediately, independent of clk. DataR therefore reads 0 for every valid LenSel during and after reset, until written. Reset takes priority over any write on the same edge.
- Addressing: base index a = Addr[9:0]. A multi-byte access touches cells a, a+1, … modulo MEM_DEPTH, so accesses wrap at 0x3FF → 0x000. Misaligned accesses are legal and need no special handling.
- Little-endian mapping: cell a holds bits [7:0], cell a+1 holds bits [15:8], and so on.
- Write: on rising clk with rst_n = 1 and MemRW = 1:
  - LenSel 00: cell a ← DataW[7:0].
  - LenSel 01: cells a..a+1 ← DataW[15:0].
  - LenSel 10: cells a..a+3 ← DataW[31:0].
  - LenSel 11: no cells change.
  - Cells outside the access are untouched.
- No write occurs when MemRW = 0.
- Read: DataR is combinational from Addr, LenSel and the memory contents, and is valid every cycle regardless of MemRW.
  - LenSel 00: {24'b0, cell a}.
  - LenSel 01: {16'b0, cell a+1, cell a}.
  - LenSel 10: {cell a+3, cell a+2, cell a+1, cell a}.
  - LenSel 11: 0.
- Read during write: before the edge, DataR shows the old contents; after the edge it shows the new contents. Zero-cycle read latency, one-edge write latency.
- There is no handshake; an access completes in the cycle it is presented.

Decomposition:
- Shared package (dmem_pkg):
  - LenSel encodings LEN_BYTE = 2'b00, LEN_HALF = 2'b01, LEN_WORD = 2'b10.
  - Derived constant MEM_ADDR_BITS = log2(MEM_DEPTH).
- Single module; no sub-module is needed.
- Byte-lane index generation (a+k modulo depth) and the read zero-extension mux live in the top module as combinational logic.

Test Plan:
1. Reset then read: pulse rst_n low, then release. Read Addr 0x0, 0x100 and 0x3FC with LenSel = 10 → DataR = 0x0000_0000 each.
2. Mixed-size writes then word reads (DataW = 0x1234_5678 throughout):
   - Writes: byte at 0x0, half at 0x2, word at 0x4, each with MemRW = 1 for one edge.
   - Then MemRW = 0, LenSel = 10. Reads: Addr 0x0 → 0x5678_0078; Addr 0x2 → 0x5678_5678; Addr 0x4 → 0x1234_5678.
3. Sub-word reads after scenario 2:
   - LenSel 00 at 0x5 → 0x0000_0056.
   - LenSel 01 at 0x6 → 0x0000_1234.
   - LenSel 01 at 0x1 → 0x0000_7800.
4. Write disable: with MemRW = 0, LenSel = 10, DataW = 0xDEAD_BEEF, Addr 0x4, apply several edges → read at 0x4 still 0x1234_5678. Then LenSel = 11 with MemRW = 1 at 0x4 → still 0x1234_5678 and DataR = 0.
5. Wrap-around: word write 0xAABB_CCDD at Addr 0x3FE → byte reads give 0x3FE = 0xDD, 0x3FF = 0xCC, 0x000 = 0xBB, 0x001 = 0xAA. Upper address bits are ignored: a word read at Addr 0x0000_13FE returns 0xAABB_CCDD.
6. Async reset mid-operation: after writes, assert rst_n low between clock edges → DataR goes to 0 without waiting for a clk edge. With MemRW = 1 held during reset, no write lands; all cells read 0 after release.
